// File: rtl/fifo_pkg.sv
// Shared defaults and threshold helper for the flagged synchronous FIFO.
package fifo_pkg;

    localparam int DefWordLength       = 8;
    localparam int DefAddrBits         = 3;
    localparam int DefAlmostEmptyThr   = 2;
    localparam int DefAlmostFullMargin = 2;

    // Almost-full threshold sits a fixed margin below the full depth.
    function automatic int almost_full_thr(input int addr_bits, input int margin);
        return (1 << addr_bits) - margin;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Storage array with one synchronous write port and one asynchronous read port.
module reg_file #(
    parameter int Width    = 8,
    parameter int AddrBits = 3
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AddrBits-1:0] waddr_i,
    input  logic [Width-1:0]    wdata_i,
    input  logic [AddrBits-1:0] raddr_i,
    output logic [Width-1:0]    rdata_o
);

    logic [Width-1:0] mem [2**AddrBits];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, almost/full/empty flags and registered read data.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WordLength     = DefWordLength,
    parameter int AddrBits       = DefAddrBits,
    parameter int AlmostFullThr  = almost_full_thr(DefAddrBits, DefAlmostFullMargin),
    parameter int AlmostEmptyThr = DefAlmostEmptyThr
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_i,
    input  logic [WordLength-1:0] w_data_i,
    input  logic                  rd_i,
    output logic [WordLength-1:0] r_data_o,
    output logic                  r_valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  almost_full_o,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                  err_clr_i,
    output logic                  overflow_o,
    output logic                  underflow_o,
`endif
    output logic [AddrBits:0]     count_o
);

    localparam int Depth = 2 ** AddrBits;
    localparam logic [AddrBits:0] DepthCnt = (AddrBits + 1)'(Depth);
    localparam logic [AddrBits:0] AfThr    = (AddrBits + 1)'(AlmostFullThr);
    localparam logic [AddrBits:0] AeThr    = (AddrBits + 1)'(AlmostEmptyThr);

    if (!(AlmostEmptyThr >= 1 && AlmostEmptyThr < AlmostFullThr && AlmostFullThr <= Depth))
    begin : g_bad_thresholds
        $error("sync_fifo_flags: need 1 <= AlmostEmptyThr < AlmostFullThr <= DEPTH");
    end

    logic [AddrBits:0]     wr_ptr;
    logic [AddrBits:0]     rd_ptr;
    logic [WordLength-1:0] rd_word;
    logic                  wr_acc;
    logic                  rd_acc;

    // Handshake: wr_i/rd_i are requests held by the producer/consumer; a request
    // takes effect only on an edge where its accept (wr_acc/rd_acc) is high, and a
    // popped word appears on r_data_o with r_valid_o=1 for exactly the next cycle.
    assign rd_acc = rd_i & ~empty_o;
    assign wr_acc = wr_i & (~full_o | rd_acc);

    assign empty_o        = (count_o == '0);
    assign full_o         = (count_o == DepthCnt);
    assign almost_full_o  = (count_o >= AfThr);
    assign almost_empty_o = (count_o <= AeThr);

    reg_file #(
        .Width    (WordLength),
        .AddrBits (AddrBits)
    ) u_storage (
        .clk_i   (clk_i),
        .we_i    (wr_acc & rst_ni),
        .waddr_i (wr_ptr[AddrBits-1:0]),
        .wdata_i (w_data_i),
        .raddr_i (rd_ptr[AddrBits-1:0]),
        .rdata_o (rd_word)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_o   <= '0;
            r_data_o  <= '0;
            r_valid_o <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                r_data_o <= rd_word;
            end
            r_valid_o <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Setting a flag wins over a clear arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_i & ~wr_acc) begin
                overflow_o <= 1'b1;
            end else if (err_clr_i) begin
                overflow_o <= 1'b0;
            end
            if (rd_i & ~rd_acc) begin
                underflow_o <= 1'b1;
            end else if (err_clr_i) begin
                underflow_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags against a queue-based occupancy model.
module tb_sync_fifo_flags;

    localparam int W     = 8;
    localparam int AB    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wr_i;
    logic [W-1:0]  w_data_i;
    logic          rd_i;
    logic [W-1:0]  r_data_o;
    logic          r_valid_o;
    logic          empty_o;
    logic          full_o;
    logic          almost_empty_o;
    logic          almost_full_o;
    logic [AB:0]   count_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          err_clr_i;
    logic          overflow_o;
    logic          underflow_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_data;
    logic         exp_valid;
    logic         exp_ovf;
    logic         exp_unf;

    always #5 clk_i = ~clk_i;

    sync_fifo_flags #(
        .WordLength     (W),
        .AddrBits       (AB),
        .AlmostFullThr  (AF),
        .AlmostEmptyThr (AE)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wr_i           (wr_i),
        .w_data_i       (w_data_i),
        .rd_i           (rd_i),
        .r_data_o       (r_data_o),
        .r_valid_o      (r_valid_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_empty_o (almost_empty_o),
        .almost_full_o  (almost_full_o),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr_i      (err_clr_i),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
`endif
        .count_o        (count_o)
    );

    // One clock of traffic: decide acceptance from the model's current occupancy,
    // then apply the edge to the model and return #1 after the edge.
    task automatic step(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr);
        bit rd_ok;
        bit wr_ok;
        wr_i     = wr;
        w_data_i = d;
        rd_i     = rd;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr_i = clr;
`endif
        rd_ok = rd && (exp_q.size() != 0);
        wr_ok = wr && ((exp_q.size() < DEPTH) || rd_ok);
        @(posedge clk_i);
        #1;
        if (rd_ok) begin
            exp_data  = exp_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (wr_ok) exp_q.push_back(d);
        if (wr && !wr_ok) exp_ovf = 1'b1;
        else if (clr)     exp_ovf = 1'b0;
        if (rd && !rd_ok) exp_unf = 1'b1;
        else if (clr)     exp_unf = 1'b0;
        wr_i = 1'b0;
        rd_i = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr_i = 1'b0;
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni   = 1'b0;
        wr_i     = 1'b1;
        rd_i     = 1'b1;
        w_data_i = 8'h5A;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr_i = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        model_reset();
        n_checks += 6;
        if (count_o !== 4'd0)      begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
        if (empty_o !== 1'b1)      begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty_o); end
        if (almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b want 1", almost_empty_o); end
        if (full_o !== 1'b0)       begin n_fail++; $display("FAIL reset_full: got %b want 0", full_o); end
        if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b want 0", almost_full_o); end
        if (r_valid_o !== 1'b0 || r_data_o !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: got valid=%b data=%h want valid=0 data=00", r_valid_o, r_data_o);
        end
        wr_i   = 1'b0;
        rd_i   = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0);
            n_checks += 4;
            if (count_o !== (AB+1)'(i)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count_o, i); end
            if (almost_full_o !== (i >= AF)) begin n_fail++; $display("FAIL fill_afull at %0d: got %b want %b", i, almost_full_o, (i >= AF)); end
            if (almost_empty_o !== (i <= AE)) begin n_fail++; $display("FAIL fill_aempty at %0d: got %b want %b", i, almost_empty_o, (i <= AE)); end
            if (full_o !== (i == DEPTH) || empty_o !== 1'b0) begin
                n_fail++; $display("FAIL fill_full at %0d: got full=%b empty=%b want full=%b empty=0", i, full_o, empty_o, (i == DEPTH));
            end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks += 2;
            if (r_valid_o !== 1'b1 || r_data_o !== W'(i)) begin
                n_fail++; $display("FAIL drain_data %0d: got valid=%b data=%h want valid=1 data=%h", i, r_valid_o, r_data_o, W'(i));
            end
            if (count_o !== (AB+1)'(DEPTH - i)) begin n_fail++; $display("FAIL drain_count: got %0d want %0d", count_o, DEPTH - i); end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks += 2;
        if (empty_o !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty_o); end
        if (r_valid_o !== 1'b0 || r_data_o !== 8'h08) begin
            n_fail++; $display("FAIL drain_hold: got valid=%b data=%h want valid=0 data=08", r_valid_o, r_data_o);
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] prev;
        prev = W'($urandom_range(0, 255));
        step(1'b1, prev, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] d;
            d = W'($urandom_range(0, 255));
            step(1'b1, d, 1'b1, 1'b0);
            n_checks += 2;
            if (count_o !== 4'd1) begin n_fail++; $display("FAIL wrap_count %0d: got %0d want 1", i, count_o); end
            if (r_valid_o !== 1'b1 || r_data_o !== prev) begin
                n_fail++; $display("FAIL wrap_data %0d: got valid=%b data=%h want valid=1 data=%h", i, r_valid_o, r_data_o, prev);
            end
            prev = d;
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks += 3;
        if (r_valid_o !== 1'b1 || r_data_o !== 8'h01) begin
            n_fail++; $display("FAIL full_rw_data: got valid=%b data=%h want valid=1 data=01", r_valid_o, r_data_o);
        end
        if (count_o !== 4'd8 || full_o !== 1'b1) begin n_fail++; $display("FAIL full_rw_count: got %0d want 8", count_o); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL full_rw_ovf: got %b want 0", overflow_o); end
`else
        if (exp_q.size() != 8 || exp_q[DEPTH-1] !== 8'h55) begin n_fail++; $display("FAIL full_rw_model: got size %0d want 8", exp_q.size()); end
`endif
        // Write into a full FIFO without a read is rejected.
        step(1'b1, 8'h66, 1'b0, 1'b0);
        n_checks += 1;
        if (count_o !== 4'd8) begin n_fail++; $display("FAIL full_wr_reject: got %0d want 8", count_o); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_checks += 1;
        if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL full_wr_ovf: got %b want 1", overflow_o); end
`endif
        for (int i = 2; i <= DEPTH + 1; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks += 1;
            if (r_data_o !== ((i <= DEPTH) ? W'(i) : 8'h55)) begin
                n_fail++; $display("FAIL full_rw_order: got %h want %h", r_data_o, (i <= DEPTH) ? W'(i) : 8'h55);
            end
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        n_checks += 2;
        if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL empty_rw_valid: got %b want 0", r_valid_o); end
        if (count_o !== 4'd1) begin n_fail++; $display("FAIL empty_rw_count: got %0d want 1", count_o); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_checks += 1;
        if (underflow_o !== 1'b1) begin n_fail++; $display("FAIL empty_rw_unf: got %b want 1", underflow_o); end
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_checks += 2;
        if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL err_clr_unf: got %b want 0", underflow_o); end
        if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL err_clr_ovf: got %b want 0", overflow_o); end
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks += 1;
        if (r_valid_o !== 1'b1 || r_data_o !== 8'hAA) begin
            n_fail++; $display("FAIL empty_rw_pop: got valid=%b data=%h want valid=1 data=aa", r_valid_o, r_data_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit clr;
            bit wr;
            bit rd;
            int c;
            wr  = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 99) < 5);
            step(wr, W'($urandom_range(0, 255)), rd, clr);
            c = exp_q.size();
            n_checks += 4;
            if (count_o !== (AB+1)'(c)) begin n_fail++; $display("FAIL rand_count %0d: got %0d want %0d", i, count_o, c); end
            if (r_valid_o !== exp_valid || r_data_o !== exp_data) begin
                n_fail++; $display("FAIL rand_data %0d: got valid=%b data=%h want valid=%b data=%h", i, r_valid_o, r_data_o, exp_valid, exp_data);
            end
            if (empty_o !== (c == 0) || full_o !== (c == DEPTH)) begin
                n_fail++; $display("FAIL rand_ef %0d: got empty=%b full=%b at count %0d", i, empty_o, full_o, c);
            end
            if (almost_empty_o !== (c <= AE) || almost_full_o !== (c >= AF)) begin
                n_fail++; $display("FAIL rand_almost %0d: got ae=%b af=%b at count %0d", i, almost_empty_o, almost_full_o, c);
            end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            n_checks += 1;
            if (overflow_o !== exp_ovf || underflow_o !== exp_unf) begin
                n_fail++; $display("FAIL rand_err %0d: got ovf=%b unf=%b want ovf=%b unf=%b", i, overflow_o, underflow_o, exp_ovf, exp_unf);
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        while (exp_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b1, 1'b0);
        n_checks += 1;
        if (count_o !== 4'd5) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 5", count_o); end
        rst_ni = 1'b0;
        wr_i   = 1'b1;
        rd_i   = 1'b1;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        wr_i   = 1'b0;
        rd_i   = 1'b0;
        model_reset();
        n_checks += 3;
        if (count_o !== 4'd0 || empty_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_count: got count=%0d empty=%b want 0 and 1", count_o, empty_o);
        end
        if (r_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", r_valid_o); end
        if (full_o !== 1'b0 || almost_full_o !== 1'b0 || almost_empty_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_flags: got full=%b af=%b ae=%b want 0 0 1", full_o, almost_full_o, almost_empty_o);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        n_checks += 1;
        if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_err: got ovf=%b unf=%b want 0 0", overflow_o, underflow_o);
        end
`endif
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks += 1;
        if (r_valid_o !== 1'b0 || count_o !== 4'd0) begin
            n_fail++; $display("FAIL post_reset_read: got valid=%b count=%0d want 0 0", r_valid_o, count_o);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_rw();
        test_empty_rw();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
